// File: rtl/mem_bus_arbiter_if.sv
// +-----------------------------------------------------------------------+
// | mem_bus_arbiter_if : pipeline-side and bus-side signals of the arbiter |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

interface mem_bus_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        mem_req;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        bus_req;
   logic        bus_wen;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        pause;
   logic        bus_err;

   // arbiter side
   modport slave (
      input  if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, mem_be,
             bus_rdata, bus_ack,
      output if_rdata, if_ready, mem_rdata, mem_ready, bus_req, bus_wen,
             bus_addr, bus_wdata, bus_be, pause, bus_err
   );

   // pipeline and memory side
   modport master (
      output if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata, mem_be,
             bus_rdata, bus_ack,
      input  if_rdata, if_ready, mem_rdata, mem_ready, bus_req, bus_wen,
             bus_addr, bus_wdata, bus_be, pause, bus_err
   );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// +-----------------------------------------------------------------------+
// | mem_bus_arbiter : shares one memory bus between fetch and load/store,  |
// | data first, with sticky completion flags and timeout abort. Rev 1.0    |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_arbiter_if.slave  arb
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_INST = 2'd2
   } state_t;

   localparam logic [15:0] c_last_cnt = 16'(TIMEOUT - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_if_done;
   logic        r_mem_done;
   logic [31:0] r_if_rdata;
   logic [31:0] r_mem_rdata;
   logic        r_bus_req;
   logic        r_bus_wen;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [3:0]  r_bus_be;
   logic        r_bus_err;

   logic w_if_pend;
   logic w_mem_pend;
   logic w_pause;
   logic w_timeout;

   assign w_if_pend  = arb.if_req & ~r_if_done;
   assign w_mem_pend = arb.mem_req & ~r_mem_done;
   assign w_pause    = w_if_pend | w_mem_pend;
   // An ack in the final allowed cycle still counts as a completion.
   assign w_timeout  = ~arb.bus_ack & (r_cnt == c_last_cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_if_done   <= 1'b0;
         r_mem_done  <= 1'b0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
         r_bus_req   <= 1'b0;
         r_bus_wen   <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_be    <= '0;
         r_bus_err   <= 1'b0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_mem_pend) begin
                  r_state     <= ST_DATA;
                  r_bus_req   <= 1'b1;
                  r_bus_wen   <= arb.mem_wen;
                  r_bus_addr  <= arb.mem_addr;
                  r_bus_wdata <= arb.mem_wdata;
                  r_bus_be    <= arb.mem_be;
               end else if (w_if_pend) begin
                  r_state     <= ST_INST;
                  r_bus_req   <= 1'b1;
                  r_bus_wen   <= 1'b0;
                  r_bus_addr  <= arb.if_addr;
                  r_bus_wdata <= '0;
                  r_bus_be    <= 4'b1111;
               end
            end
            ST_DATA, ST_INST: begin
               if (arb.bus_ack || w_timeout) begin
                  r_state   <= ST_IDLE;
                  r_bus_req <= 1'b0;
                  r_cnt     <= '0;
                  r_bus_err <= w_timeout;
                  if (r_state == ST_DATA) begin
                     r_mem_done  <= 1'b1;
                     r_mem_rdata <= (arb.bus_ack && !r_bus_wen) ? arb.bus_rdata : '0;
                  end else begin
                     r_if_done  <= 1'b1;
                     r_if_rdata <= arb.bus_ack ? arb.bus_rdata : '0;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         // Pipeline advance wins over any flag set in the same cycle.
         if (!w_pause) begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
         end
      end
   end

   assign arb.if_ready  = r_if_done;
   assign arb.mem_ready = r_mem_done;
   assign arb.if_rdata  = r_if_rdata;
   assign arb.mem_rdata = r_mem_rdata;
   assign arb.bus_req   = r_bus_req;
   assign arb.bus_wen   = r_bus_wen;
   assign arb.bus_addr  = r_bus_addr;
   assign arb.bus_wdata = r_bus_wdata;
   assign arb.bus_be    = r_bus_be;
   assign arb.bus_err   = r_bus_err;
   assign arb.pause     = w_pause;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_mem_bus_arbiter : randomized pipeline/memory stimulus against a     |
// | transaction-level reference model. Rev 1.0                             |
// +-----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mem_bus_arbiter;
   localparam int TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bus_if ();

   mem_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .arb (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_if_rdata;
   logic [31:0] exp_mem_rdata;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic apply(input bit want_if, input bit want_mem);
      bus_if.if_req    = want_if;
      bus_if.if_addr   = $urandom & 32'hFFFF_FFFC;
      bus_if.mem_req   = want_mem;
      bus_if.mem_wen   = 1'($urandom_range(0, 1));
      bus_if.mem_addr  = $urandom & 32'hFFFF_FFFC;
      bus_if.mem_wdata = $urandom;
      bus_if.mem_be    = 4'($urandom_range(1, 15));
   endtask

   // One bus transaction: grant, exact bus fields, ack after d wait cycles
   // (or abort when d >= TIMEOUT), then captured data and flags.
   task automatic do_txn(input bit is_mem, input int d, input logic [31:0] data);
      int w;
      int k;
      bit timed;
      logic [31:0] exp_d;
      @(negedge clk);
      w = 0;
      while (!bus_if.bus_req && w < 4) begin
         @(negedge clk);
         w++;
      end
      check_val(is_mem ? "grant_wait_mem" : "grant_wait_if", 32'(w), 32'd0);
      check_val("bus_wen",   {31'd0, bus_if.bus_wen},  is_mem ? {31'd0, bus_if.mem_wen} : 32'd0);
      check_val("bus_addr",  bus_if.bus_addr,  is_mem ? bus_if.mem_addr : bus_if.if_addr);
      check_val("bus_wdata", bus_if.bus_wdata, is_mem ? bus_if.mem_wdata : 32'd0);
      check_val("bus_be",    {28'd0, bus_if.bus_be}, is_mem ? {28'd0, bus_if.mem_be} : 32'hF);
      k = 0;
      while (bus_if.bus_req && k < TIMEOUT + 2) begin
         bus_if.bus_ack   = (k == d);
         bus_if.bus_rdata = (k == d) ? data : $urandom;
         check_val("pause_busy", {31'd0, bus_if.pause}, 32'd1);
         @(negedge clk);
         bus_if.bus_ack = 1'b0;
         k++;
      end
      timed = (d >= TIMEOUT);
      check_val("busy_len", 32'(k), timed ? 32'(TIMEOUT) : 32'(d + 1));
      check_val("bus_err", {31'd0, bus_if.bus_err}, {31'd0, timed});
      exp_d = (timed || (is_mem && bus_if.mem_wen)) ? 32'd0 : data;
      if (is_mem) begin
         exp_mem_rdata = exp_d;
         check_val("mem_ready_set", {31'd0, bus_if.mem_ready}, 32'd1);
      end else begin
         exp_if_rdata = exp_d;
         check_val("if_ready_set", {31'd0, bus_if.if_ready}, 32'd1);
      end
      check_val("if_rdata",  bus_if.if_rdata,  exp_if_rdata);
      check_val("mem_rdata", bus_if.mem_rdata, exp_mem_rdata);
   endtask

   // One pipeline cycle whose requests are already applied.
   task automatic run_op(input bit want_if, input bit want_mem, input int d_mem, input int d_if,
                         input logic [31:0] data_mem, input logic [31:0] data_if);
      if (want_mem) begin
         do_txn(1'b1, d_mem, data_mem);
         check_val("pause_after_mem", {31'd0, bus_if.pause}, {31'd0, want_if});
         check_val("if_ready_wait", {31'd0, bus_if.if_ready}, 32'd0);
      end
      if (want_if)
         do_txn(1'b0, d_if, data_if);
      if (!want_if && !want_mem) begin
         bus_if.bus_ack   = 1'b1;
         bus_if.bus_rdata = $urandom;
         @(negedge clk);
         bus_if.bus_ack = 1'b0;
         check_val("stray_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      end
      check_val("pause_done",  {31'd0, bus_if.pause},     32'd0);
      check_val("if_ready",    {31'd0, bus_if.if_ready},  {31'd0, want_if});
      check_val("mem_ready",   {31'd0, bus_if.mem_ready}, {31'd0, want_mem});
      @(negedge clk);
      check_val("if_ready_clr",  {31'd0, bus_if.if_ready},  32'd0);
      check_val("mem_ready_clr", {31'd0, bus_if.mem_ready}, 32'd0);
      check_val("bus_err_clr",   {31'd0, bus_if.bus_err},   32'd0);
      check_val("bus_req_idle",  {31'd0, bus_if.bus_req},   32'd0);
      check_val("if_rdata_hold", bus_if.if_rdata,  exp_if_rdata);
      check_val("mem_rdata_hold", bus_if.mem_rdata, exp_mem_rdata);
      bus_if.if_req  = 1'b0;
      bus_if.mem_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit wi;
      bit wm;
      apply(1'b0, 1'b0);
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;
      exp_if_rdata  = '0;
      exp_mem_rdata = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_bus_req",   {31'd0, bus_if.bus_req},   32'd0);
      check_val("rst_bus_addr",  bus_if.bus_addr,           32'd0);
      check_val("rst_bus_be",    {28'd0, bus_if.bus_be},    32'd0);
      check_val("rst_if_ready",  {31'd0, bus_if.if_ready},  32'd0);
      check_val("rst_mem_ready", {31'd0, bus_if.mem_ready}, 32'd0);
      check_val("rst_if_rdata",  bus_if.if_rdata,           32'd0);
      check_val("rst_bus_err",   {31'd0, bus_if.bus_err},   32'd0);
      check_val("rst_pause",     {31'd0, bus_if.pause},     32'd0);
      rst = 1'b0;

      // reset while a load is on the bus, then the held request re-issues
      apply(1'b0, 1'b1);
      bus_if.mem_wen  = 1'b0;
      bus_if.mem_addr = 32'h1001_0004;
      @(negedge clk);
      check_val("mid_bus_req_up", {31'd0, bus_if.bus_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check_val("mid_rst_bus_req",   {31'd0, bus_if.bus_req},   32'd0);
      check_val("mid_rst_mem_ready", {31'd0, bus_if.mem_ready}, 32'd0);
      check_val("mid_rst_pause",     {31'd0, bus_if.pause},     32'd1);
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b0, 1'b1, 0, 0, 32'h1234_5678, 32'd0);

      // single fetch, first-cycle ack
      apply(1'b1, 1'b0);
      bus_if.if_addr = 32'h0040_0000;
      run_op(1'b1, 1'b0, 0, 0, 32'd0, 32'h2402_0005);

      // simultaneous store and fetch, two wait cycles each
      apply(1'b1, 1'b1);
      bus_if.mem_wen   = 1'b1;
      bus_if.mem_addr  = 32'h1001_0000;
      bus_if.mem_wdata = 32'hDEAD_BEEF;
      bus_if.mem_be    = 4'b0011;
      run_op(1'b1, 1'b1, 2, 2, $urandom, $urandom);

      // fetch timeout, then a stray ack with nothing requested
      apply(1'b1, 1'b0);
      run_op(1'b1, 1'b0, 0, TIMEOUT + 1, 32'd0, $urandom);
      apply(1'b0, 1'b0);
      run_op(1'b0, 1'b0, 0, 0, 32'd0, 32'd0);

      for (int i = 0; i < 60; i++) begin
         wi = 1'($urandom_range(0, 1));
         wm = 1'($urandom_range(0, 1));
         apply(wi, wm);
         run_op(wi, wm, $urandom_range(0, TIMEOUT + 1), $urandom_range(0, TIMEOUT + 1),
                $urandom, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire
